flood_fill_engine: RTL and testbench

- Owns the live game board and applies Flood-It moves to it.
- Sits between the board generator, the selection/controller FSM and the VGA renderer.
- Receives the generated board as a write stream and seeds the flood region from cell (0,0).
- On each colour command, recolours the region, absorbs matching neighbours, counts moves and flags a win.

---
 rtl/flood_fill_engine_if.sv | 30 +++
 rtl/flood_fill_engine.sv | 155 +++++++++++++++
 tb/tb_flood_fill_engine.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/flood_fill_engine_if.sv
// Command, load and read-back bus between the Flood-It engine and its neighbours
// (board generator, controller FSM, VGA renderer).
interface flood_fill_engine_if #(
    parameter int CW = 3,
    parameter int MW = 8
);
    logic [4:0]    SIZE;
    logic          LOAD_EN;
    logic [9:0]    LOAD_ADDR;
    logic [CW-1:0] LOAD_COLOR;
    logic          NEW_BOARD;
    logic          START;
    logic [CW-1:0] COLOR_IN;
    logic          BUSY;
    logic          DONE;
    logic          CHANGED;
    logic          WON;
    logic [MW-1:0] MOVES;
    logic [9:0]    RD_ADDR;
    logic [CW-1:0] RD_COLOR;

    modport master (
        output SIZE, LOAD_EN, LOAD_ADDR, LOAD_COLOR, NEW_BOARD, START, COLOR_IN, RD_ADDR,
        input  BUSY, DONE, CHANGED, WON, MOVES, RD_COLOR
    );
    modport slave (
        input  SIZE, LOAD_EN, LOAD_ADDR, LOAD_COLOR, NEW_BOARD, START, COLOR_IN, RD_ADDR,
        output BUSY, DONE, CHANGED, WON, MOVES, RD_COLOR
    );
endinterface

// File: rtl/flood_fill_engine.sv
// Flood-It board owner: loads the board, grows the (0,0) region by repeated raster
// sweeps until a pass absorbs nothing, then reports moves and win status.
module flood_fill_engine #(
    parameter int MAX_N = 26,
    parameter int CW    = 3,
    parameter int MW    = 8
) (
    input  logic          CLOCK,
    input  logic          RESET,
    flood_fill_engine_if.slave bus
);
    localparam int         CELLS   = MAX_N * MAX_N;
    localparam logic [9:0] CELLS_A = 10'(CELLS);
    localparam logic [9:0] STRIDE  = 10'(MAX_N);

    typedef enum logic [1:0] {IDLE, SEED, SWEEP, FINISH} state_t;

    state_t          r_state;
    logic [CW-1:0]   r_color [CELLS];
    logic [CELLS-1:0] r_region;
    logic [CW-1:0]   r_target;
    logic [4:0]      r_n, r_row, r_col;
    logic            r_grew, r_incomplete, r_is_start;
    logic            r_busy, r_done, r_changed, r_won;
    logic [MW-1:0]   r_moves;
    logic [CW-1:0]   r_rd_color;

    logic [9:0]      w_idx, w_waddr;
    logic [4:0]      w_size;
    logic            w_in_reg, w_nbr, w_absorb, w_last, w_we;
    logic [CW-1:0]   w_cur, w_wdata;

    always_comb begin
        w_size = bus.SIZE;
        if (bus.SIZE < 5'd2)             w_size = 5'd2;
        else if (bus.SIZE > 5'(MAX_N))   w_size = 5'(MAX_N);

        w_idx    = 10'(r_row) * STRIDE + 10'(r_col);
        w_in_reg = r_region[w_idx];
        w_cur    = r_color[w_idx];
        // Neighbour lookups are guarded so no index outside the N*N area is used.
        w_nbr    = ((r_row != 5'd0)       && r_region[w_idx - STRIDE]) ||
                   ((r_row != r_n - 5'd1) && r_region[w_idx + STRIDE]) ||
                   ((r_col != 5'd0)       && r_region[w_idx - 10'd1])  ||
                   ((r_col != r_n - 5'd1) && r_region[w_idx + 10'd1]);
        w_absorb = (r_state == SWEEP) && !w_in_reg && (w_cur == r_target) && w_nbr;
        w_last   = (r_row == r_n - 5'd1) && (r_col == r_n - 5'd1);

        w_we    = 1'b0;
        w_waddr = bus.LOAD_ADDR;
        w_wdata = bus.LOAD_COLOR;
        if (!RESET) begin
            if (r_state == IDLE && bus.LOAD_EN && bus.LOAD_ADDR < CELLS_A) begin
                w_we = 1'b1;
            end else if (r_state == SWEEP && w_in_reg) begin
                w_we    = 1'b1;
                w_waddr = w_idx;
                w_wdata = r_target;
            end
        end
    end

    // Colour storage is deliberately left without reset.
    always_ff @(posedge CLOCK) begin
        if (w_we) r_color[w_waddr] <= w_wdata;
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) r_rd_color <= '0;
        else       r_rd_color <= (bus.RD_ADDR < CELLS_A) ? r_color[bus.RD_ADDR] : '0;
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            r_state      <= IDLE;
            r_region     <= '0;
            r_target     <= '0;
            r_n          <= 5'd2;
            r_row        <= '0;
            r_col        <= '0;
            r_grew       <= 1'b0;
            r_incomplete <= 1'b0;
            r_is_start   <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_changed    <= 1'b0;
            r_won        <= 1'b0;
            r_moves      <= '0;
        end else begin
            r_done    <= 1'b0;
            r_changed <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.NEW_BOARD) begin
                        r_n        <= w_size;
                        r_region   <= {{(CELLS-1){1'b0}}, 1'b1};
                        r_target   <= r_color[0];
                        r_moves    <= '0;
                        r_won      <= 1'b0;
                        r_is_start <= 1'b0;
                        r_busy     <= 1'b1;
                        r_state    <= SEED;
                    end else if (bus.START) begin
                        if (bus.COLOR_IN == r_target || r_won) begin
                            r_done <= 1'b1;
                        end else begin
                            r_target   <= bus.COLOR_IN;
                            if (r_moves != {MW{1'b1}}) r_moves <= r_moves + 1'b1;
                            r_is_start <= 1'b1;
                            r_busy     <= 1'b1;
                            r_state    <= SEED;
                        end
                    end
                end
                SEED: begin
                    r_grew       <= 1'b0;
                    r_incomplete <= 1'b0;
                    r_row        <= '0;
                    r_col        <= '0;
                    r_state      <= SWEEP;
                end
                SWEEP: begin
                    if (w_absorb) begin
                        r_region[w_idx] <= 1'b1;
                        r_grew          <= 1'b1;
                    end else if (!w_in_reg) begin
                        r_incomplete <= 1'b1;
                    end
                    if (r_col == r_n - 5'd1) begin
                        r_col <= '0;
                        r_row <= r_row + 5'd1;
                    end else begin
                        r_col <= r_col + 5'd1;
                    end
                    if (w_last) r_state <= (r_grew || w_absorb) ? SEED : FINISH;
                end
                FINISH: begin
                    r_won     <= ~r_incomplete;
                    r_done    <= 1'b1;
                    r_changed <= r_is_start;
                    r_busy    <= 1'b0;
                    r_state   <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.BUSY     = r_busy;
    assign bus.DONE     = r_done;
    assign bus.CHANGED  = r_changed;
    assign bus.WON      = r_won;
    assign bus.MOVES    = r_moves;
    assign bus.RD_COLOR = r_rd_color;
endmodule

// File: tb/tb_flood_fill_engine.sv
// Directed bench for flood_fill_engine: seeding, moves, multi-pass growth, clamping,
// saturation and reset abort, with hand-computed latencies and colours.
module tb_flood_fill_engine;
    logic CLOCK, RESET;
    int   errors = 0;
    int   checks = 0;

    flood_fill_engine_if #(.CW(3), .MW(8)) b();

    flood_fill_engine #(.MAX_N(26), .CW(3), .MW(8)) dut (
        .CLOCK (CLOCK),
        .RESET (RESET),
        .bus   (b.slave)
    );

    initial begin
        CLOCK = 1'b0;
        forever #5 CLOCK = ~CLOCK;
    end

    task automatic load(input int addr, input logic [2:0] col);
        b.LOAD_EN = 1'b1; b.LOAD_ADDR = 10'(addr); b.LOAD_COLOR = col;
        @(negedge CLOCK);
        b.LOAD_EN = 1'b0;
    endtask

    task automatic rd(input int addr, output logic [2:0] col);
        b.RD_ADDR = 10'(addr);
        @(negedge CLOCK);
        col = b.RD_COLOR;
    endtask

    // Issue one command and count edges (sampling edge = 1) until DONE; optionally
    // pulse an extra START at edge count inj while the engine works.
    task automatic run_cmd(input bit nb, input logic [2:0] col, input int inj,
                           output int lat, output bit saw_busy);
        saw_busy = 1'b0;
        if (nb) b.NEW_BOARD = 1'b1; else b.START = 1'b1;
        b.COLOR_IN = col;
        @(negedge CLOCK);
        b.NEW_BOARD = 1'b0; b.START = 1'b0;
        lat = 1;
        while (b.DONE !== 1'b1 && lat < 5000) begin
            if (b.BUSY === 1'b1) saw_busy = 1'b1;
            if (lat == inj) begin b.START = 1'b1; b.COLOR_IN = 3'd1; end
            @(negedge CLOCK);
            b.START = 1'b0;
            lat++;
        end
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        repeat (2) @(negedge CLOCK);
        checks++; if (b.BUSY !== 1'b0)  begin errors++; $display("FAIL reset_busy got=%0b exp=0", b.BUSY); end
        checks++; if (b.DONE !== 1'b0)  begin errors++; $display("FAIL reset_done got=%0b exp=0", b.DONE); end
        checks++; if (b.WON !== 1'b0)   begin errors++; $display("FAIL reset_won got=%0b exp=0", b.WON); end
        checks++; if (b.MOVES !== 8'd0) begin errors++; $display("FAIL reset_moves got=%0d exp=0", b.MOVES); end
        checks++; if (b.RD_COLOR !== 3'd0) begin errors++; $display("FAIL reset_rd got=%0d exp=0", b.RD_COLOR); end
        RESET = 1'b0;
        @(negedge CLOCK);
    endtask

    task automatic test_seed();
        int lat; bit bz; logic [2:0] c;
        b.SIZE = 5'd4;
        for (int r = 0; r < 4; r++)
            for (int k = 0; k < 4; k++) load(r*26 + k, 3'((r + k) & 1));
        run_cmd(1'b1, 3'd0, 0, lat, bz);
        checks++; if (lat != 19)         begin errors++; $display("FAIL seed_latency got=%0d exp=19", lat); end
        checks++; if (b.CHANGED !== 1'b0) begin errors++; $display("FAIL seed_changed got=%0b exp=0", b.CHANGED); end
        checks++; if (b.WON !== 1'b0)    begin errors++; $display("FAIL seed_won got=%0b exp=0", b.WON); end
        checks++; if (bz !== 1'b1)       begin errors++; $display("FAIL seed_busy got=%0b exp=1", bz); end
        rd(1, c);
        checks++; if (c !== 3'd1)        begin errors++; $display("FAIL seed_rd01 got=%0d exp=1", c); end
        // Same colour as the current target: immediate DONE, nothing counted.
        run_cmd(1'b0, 3'd0, 0, lat, bz);
        checks++; if (lat != 1)          begin errors++; $display("FAIL same_latency got=%0d exp=1", lat); end
        checks++; if (b.CHANGED !== 1'b0) begin errors++; $display("FAIL same_changed got=%0b exp=0", b.CHANGED); end
        checks++; if (bz !== 1'b0 || b.BUSY !== 1'b0) begin errors++; $display("FAIL same_busy got=%0b exp=0", bz); end
        checks++; if (b.MOVES !== 8'd0)  begin errors++; $display("FAIL same_moves got=%0d exp=0", b.MOVES); end
    endtask

    task automatic test_single_pass();
        int lat; bit bz; logic [2:0] c;
        logic [2:0] bd [9] = '{3'd0, 3'd0, 3'd1, 3'd2, 3'd2, 3'd1, 3'd1, 3'd1, 3'd1};
        b.SIZE = 5'd3;
        for (int i = 0; i < 9; i++) load((i / 3) * 26 + (i % 3), bd[i]);
        run_cmd(1'b1, 3'd0, 0, lat, bz);
        checks++; if (lat != 22)  begin errors++; $display("FAIL sp_nb_latency got=%0d exp=22", lat); end
        run_cmd(1'b0, 3'd2, 0, lat, bz);
        checks++; if (lat != 22 || b.WON !== 1'b0) begin errors++; $display("FAIL sp_mv2 lat=%0d won=%0b exp 22/0", lat, b.WON); end
        run_cmd(1'b0, 3'd1, 0, lat, bz);
        checks++; if (lat != 22)  begin errors++; $display("FAIL sp_mv1_latency got=%0d exp=22", lat); end
        checks++; if (b.CHANGED !== 1'b1) begin errors++; $display("FAIL sp_changed got=%0b exp=1", b.CHANGED); end
        checks++; if (b.WON !== 1'b1)     begin errors++; $display("FAIL sp_won got=%0b exp=1", b.WON); end
        checks++; if (b.MOVES !== 8'd2)   begin errors++; $display("FAIL sp_moves got=%0d exp=2", b.MOVES); end
        for (int i = 0; i < 9; i++) begin
            rd((i / 3) * 26 + (i % 3), c);
            checks++; if (c !== 3'd1) begin errors++; $display("FAIL sp_rd cell=%0d got=%0d exp=1", i, c); end
        end
        run_cmd(1'b0, 3'd3, 0, lat, bz);
        checks++; if (lat != 1 || b.CHANGED !== 1'b0 || b.MOVES !== 8'd2)
            begin errors++; $display("FAIL sp_won_start lat=%0d chg=%0b mv=%0d exp 1/0/2", lat, b.CHANGED, b.MOVES); end
        // Read and write to the same cell in one cycle returns the old colour.
        b.RD_ADDR = 10'd0;
        load(0, 3'd5);
        c = b.RD_COLOR;
        checks++; if (c !== 3'd1) begin errors++; $display("FAIL rw_same_cycle got=%0d exp=1", c); end
        rd(0, c);
        checks++; if (c !== 3'd5) begin errors++; $display("FAIL rw_after got=%0d exp=5", c); end
    endtask

    task automatic test_multi_pass();
        int lat; bit bz; logic [2:0] c;
        logic [2:0] bd [25] = '{3'd0, 3'd2, 3'd1, 3'd2, 3'd2,
                                3'd1, 3'd2, 3'd1, 3'd2, 3'd1,
                                3'd1, 3'd2, 3'd2, 3'd2, 3'd1,
                                3'd1, 3'd1, 3'd1, 3'd1, 3'd1,
                                3'd1, 3'd1, 3'd1, 3'd1, 3'd1};
        b.SIZE = 5'd5;
        for (int i = 0; i < 25; i++) load((i / 5) * 26 + (i % 5), bd[i]);
        run_cmd(1'b1, 3'd0, 0, lat, bz);
        checks++; if (lat != 28) begin errors++; $display("FAIL mp_nb_latency got=%0d exp=28", lat); end
        // Four passes: the path winds down, right, and back up to (0,3),(0,4).
        run_cmd(1'b0, 3'd2, 3, lat, bz);
        checks++; if (lat != 106)        begin errors++; $display("FAIL mp_latency got=%0d exp=106", lat); end
        checks++; if (b.MOVES !== 8'd1)  begin errors++; $display("FAIL busy_start_moves got=%0d exp=1", b.MOVES); end
        checks++; if (b.WON !== 1'b0)    begin errors++; $display("FAIL mp_won got=%0b exp=0", b.WON); end
        rd(0, c);
        checks++; if (c !== 3'd2)        begin errors++; $display("FAIL mp_rd00 got=%0d exp=2", c); end
        run_cmd(1'b0, 3'd1, 0, lat, bz);
        checks++; if (lat != 54 || b.WON !== 1'b1)
            begin errors++; $display("FAIL mp_final lat=%0d won=%0b exp 54/1", lat, b.WON); end
    endtask

    task automatic test_clamp();
        int lat; bit bz;
        b.SIZE = 5'd31;
        for (int i = 0; i < 676; i++) load(i, 3'd3);
        run_cmd(1'b1, 3'd0, 0, lat, bz);
        checks++; if (lat != 1356 || b.WON !== 1'b1)
            begin errors++; $display("FAIL clamp_hi lat=%0d won=%0b exp 1356/1", lat, b.WON); end
        b.SIZE = 5'd0;
        run_cmd(1'b1, 3'd0, 0, lat, bz);
        checks++; if (lat != 12 || b.WON !== 1'b1)
            begin errors++; $display("FAIL clamp_lo lat=%0d won=%0b exp 12/1", lat, b.WON); end
    endtask

    task automatic test_saturate();
        int lat; bit bz; logic [2:0] c;
        b.SIZE = 5'd2;
        load(0, 3'd0); load(1, 3'd7); load(26, 3'd7); load(27, 3'd7);
        run_cmd(1'b1, 3'd0, 0, lat, bz);
        checks++; if (lat != 7) begin errors++; $display("FAIL sat_nb_latency got=%0d exp=7", lat); end
        for (int i = 0; i < 255; i++) run_cmd(1'b0, (i % 2) ? 3'd2 : 3'd1, 0, lat, bz);
        checks++; if (b.MOVES !== 8'd255) begin errors++; $display("FAIL sat_255 got=%0d exp=255", b.MOVES); end
        run_cmd(1'b0, 3'd2, 0, lat, bz);
        checks++; if (b.MOVES !== 8'd255 || b.CHANGED !== 1'b1 || lat != 7)
            begin errors++; $display("FAIL sat_hold mv=%0d chg=%0b lat=%0d exp 255/1/7", b.MOVES, b.CHANGED, lat); end
        rd(0, c);
        checks++; if (c !== 3'd2) begin errors++; $display("FAIL sat_rd0 got=%0d exp=2", c); end
        rd(2, c);
        checks++; if (c !== 3'd3) begin errors++; $display("FAIL outside_untouched got=%0d exp=3", c); end
    endtask

    task automatic test_reset_mid();
        bit saw_done = 1'b0;
        b.START = 1'b1; b.COLOR_IN = 3'd1;
        @(negedge CLOCK);
        b.START = 1'b0;
        repeat (3) @(negedge CLOCK);
        RESET = 1'b1;
        @(negedge CLOCK);
        RESET = 1'b0;
        checks++; if (b.BUSY !== 1'b0)  begin errors++; $display("FAIL rst_mid_busy got=%0b exp=0", b.BUSY); end
        checks++; if (b.MOVES !== 8'd0) begin errors++; $display("FAIL rst_mid_moves got=%0d exp=0", b.MOVES); end
        for (int i = 0; i < 20; i++) begin
            @(negedge CLOCK);
            if (b.DONE === 1'b1 || b.BUSY === 1'b1) saw_done = 1'b1;
        end
        checks++; if (saw_done !== 1'b0) begin errors++; $display("FAIL rst_mid_idle got=%0b exp=0", saw_done); end
    endtask

    initial begin
        RESET = 1'b1; b.SIZE = 5'd4; b.LOAD_EN = 1'b0; b.LOAD_ADDR = '0; b.LOAD_COLOR = '0;
        b.NEW_BOARD = 1'b0; b.START = 1'b0; b.COLOR_IN = '0; b.RD_ADDR = '0;
        @(negedge CLOCK);
        test_reset();
        test_seed();
        test_single_pass();
        test_multi_pass();
        test_clamp();
        test_saturate();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
